// File: rtl/inj_ctrl.sv
// -----------------------------------------------------------------------------
// inj_ctrl -- local-injection controller for the bufferless deflection router.
//
// Buffers flits from the cache-miss source in a small FIFO and releases the
// oldest one only in a cycle where fewer than four network flits are present
// in the stage, so combone always has a free output port for it.  A saturating
// counter tracks consecutive blocked cycles and raises 'starve' when it tops out.
//
// Optional feature: define INJ_BYPASS_EN to let a flit arriving at an empty
// FIFO inject in the same cycle (zero-cycle latency, FIFO not written).
//
// Ports:
//   clk        in   router clock, rising edge
//   rst        in   synchronous active-high reset
//   lin_data   in   flit offered by the cache-miss source
//   lin_valid  in   lin_data valid this cycle
//   lin_ready  out  controller accepts lin_data this cycle (FIFO not full)
//   nin/sin/ein/win in  network flits entering combone; MSB = valid
//   inj_flit   out  flit driven to combone lin (valid bit forced), else zero
//   inj_fire   out  an injection occurs this cycle
//   starve     out  injection blocked for STARVE_MAX consecutive cycles
//   fifo_count out  current FIFO occupancy
// -----------------------------------------------------------------------------
module inj_ctrl #(
  parameter int FLIT_W     = 10,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        lin_data,
  input  logic                     lin_valid,
  output logic                     lin_ready,
  input  logic [FLIT_W-1:0]        nin,
  input  logic [FLIT_W-1:0]        sin,
  input  logic [FLIT_W-1:0]        ein,
  input  logic [FLIT_W-1:0]        win,
  output logic [FLIT_W-1:0]        inj_flit,
  output logic                     inj_fire,
  output logic                     starve,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [FLIT_W-1:0] VALID_MASK = {1'b1, {(FLIT_W-1){1'b0}}};

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;

  logic [3:0]        net_valid;
  logic [2:0]        occ;
  logic              free;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              bypass;
  logic [FLIT_W-1:0] head;

  // Network occupancy of the stage: one valid bit per incoming port.
  assign net_valid = {win[FLIT_W-1], ein[FLIT_W-1], sin[FLIT_W-1], nin[FLIT_W-1]};

  always_comb begin
    occ = 3'd0;
    for (int i = 0; i < 4; i++) begin
      occ = occ + 3'(net_valid[i]);
    end
  end

  assign free  = (occ < 3'd4);
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Readiness looks only at the registered count; a same-cycle pop never
  // opens space for a push into a full FIFO.
  assign lin_ready = !full;
  assign pop       = !empty && free;

`ifdef INJ_BYPASS_EN
  // Empty FIFO: hand the incoming flit straight to combone, skip the write.
  assign bypass = empty && lin_valid && free;
`else
  assign bypass = 1'b0;
`endif

  assign push     = lin_valid && lin_ready && !bypass;
  assign inj_fire = pop || bypass;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    inj_flit = '0;
    if (pop) begin
      inj_flit = head | VALID_MASK;
    end else if (bypass) begin
      inj_flit = lin_data | VALID_MASK;
    end
  end

  // Next-state: pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    starve_cnt_d = starve_cnt_q;
    if (inj_fire || empty) begin
      starve_cnt_d = '0;
    end else if (!free && (starve_cnt_q != SW'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Storage carries no reset; a write in the reset cycle is dropped so the
  // FIFO contents never reflect a discarded push.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= lin_data;
    end
  end

  assign starve     = (starve_cnt_q == SW'(STARVE_MAX));
  assign fifo_count = count_q;

endmodule

// File: tb/tb_inj_ctrl.sv
module tb_inj_ctrl;
  localparam int FLIT_W     = 10;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [FLIT_W-1:0] lin_data;
  logic              lin_valid;
  logic              lin_ready;
  logic [FLIT_W-1:0] nin, sin, ein, win;
  logic [FLIT_W-1:0] inj_flit;
  logic              inj_fire;
  logic              starve;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending flits plus a blocked-cycle counter.
  logic [FLIT_W-1:0] mq [$];
  int                mstarve = 0;

  always #5 clk = ~clk;

  inj_ctrl #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .lin_data(lin_data), .lin_valid(lin_valid),
    .lin_ready(lin_ready), .nin(nin), .sin(sin), .ein(ein), .win(win),
    .inj_flit(inj_flit), .inj_fire(inj_fire), .starve(starve),
    .fifo_count(fifo_count)
  );

  task automatic drive_net(input logic [3:0] v);
    nin = {v[0], (FLIT_W-1)'($urandom)};
    sin = {v[1], (FLIT_W-1)'($urandom)};
    ein = {v[2], (FLIT_W-1)'($urandom)};
    win = {v[3], (FLIT_W-1)'($urandom)};
  endtask

  task automatic set_occ(input int n);
    logic [3:0] v;
    v = 4'b0000;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    drive_net(v);
  endtask

  function automatic int cur_occ();
    return int'(nin[FLIT_W-1]) + int'(sin[FLIT_W-1]) + int'(ein[FLIT_W-1]) + int'(win[FLIT_W-1]);
  endfunction

  // Advance one clock edge and apply the same edge to the reference model.
  task automatic tick();
    bit free, bp, fire, push, pop;
    free = cur_occ() < 4;
    bp = 1'b0;
`ifdef INJ_BYPASS_EN
    bp = (mq.size() == 0) && lin_valid && free;
`endif
    pop  = (mq.size() != 0) && free;
    fire = pop || bp;
    push = lin_valid && (mq.size() != DEPTH) && !bp;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mstarve = 0;
    end else begin
      if (fire || mq.size() == 0) mstarve = 0;
      else if (!free && mstarve < STARVE_MAX) mstarve++;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(lin_data);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; lin_valid = 1'b0; lin_data = '0; drive_net(4'b0000);
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (lin_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", lin_ready); end
      checks++; if (inj_fire !== 1'b0) begin errors++; $display("FAIL reset_fire: got %b expected 0", inj_fire); end
      checks++; if (inj_flit !== '0) begin errors++; $display("FAIL reset_flit: got %h expected 000", inj_flit); end
      checks++; if (starve !== 1'b0) begin errors++; $display("FAIL reset_starve: got %b expected 0", starve); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
      tick();
    end
    $display("reset: idle for 3 cycles");
  endtask

  task automatic test_single();
    lin_valid = 1'b1; lin_data = 10'h2A5; set_occ(2);
    #1;
`ifdef INJ_BYPASS_EN
    checks++; if (inj_fire !== 1'b1 || inj_flit !== 10'h2A5) begin errors++; $display("FAIL single_bypass: got fire=%b flit=%h expected fire=1 flit=2a5", inj_fire, inj_flit); end
`else
    checks++; if (inj_fire !== 1'b0 || inj_flit !== '0) begin errors++; $display("FAIL single_c0: got fire=%b flit=%h expected fire=0 flit=000", inj_fire, inj_flit); end
`endif
    tick();
    lin_valid = 1'b0;
    #1;
`ifndef INJ_BYPASS_EN
    checks++; if (inj_fire !== 1'b1 || inj_flit !== 10'h2A5) begin errors++; $display("FAIL single_c1: got fire=%b flit=%h expected fire=1 flit=2a5", inj_fire, inj_flit); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_cnt1: got %0d expected 1", fifo_count); end
`endif
    $display("single: inject %h", inj_flit);
    tick();
    #1;
    checks++; if (fifo_count !== 3'd0 || inj_fire !== 1'b0) begin errors++; $display("FAIL single_c2: got count=%0d fire=%b expected count=0 fire=0", fifo_count, inj_fire); end
  endtask

  task automatic test_full_order();
    set_occ(4);
    for (int k = 0; k < 4; k++) begin
      lin_valid = 1'b1; lin_data = 10'h201 + 10'(k);
      #1;
      checks++; if (lin_ready !== 1'b1 || inj_fire !== 1'b0) begin errors++; $display("FAIL full_push%0d: got ready=%b fire=%b expected ready=1 fire=0", k, lin_ready, inj_fire); end
      tick();
    end
    lin_data = 10'h3FF;
    #1;
    checks++; if (fifo_count !== 3'd4 || lin_ready !== 1'b0) begin errors++; $display("FAIL full_state: got count=%0d ready=%b expected count=4 ready=0", fifo_count, lin_ready); end
    tick();
    lin_valid = 1'b0; set_occ(3);
    #1;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_ignore: got count=%0d expected 4", fifo_count); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (inj_fire !== 1'b1 || inj_flit !== 10'h201 + 10'(k)) begin errors++; $display("FAIL full_order%0d: got fire=%b flit=%h expected fire=1 flit=%h", k, inj_fire, inj_flit, 10'h201 + 10'(k)); end
      $display("full: inject %h", inj_flit);
      tick();
      #1;
    end
    checks++; if (fifo_count !== 3'd0 || inj_fire !== 1'b0) begin errors++; $display("FAIL full_drain: got count=%0d fire=%b expected count=0 fire=0", fifo_count, inj_fire); end
  endtask

  task automatic test_starve();
    set_occ(4); lin_valid = 1'b1; lin_data = 10'h0AB;
    tick();
    lin_valid = 1'b0;
    for (int i = 0; i < STARVE_MAX; i++) begin
      drive_net(4'b1111);
      #1;
      checks++; if (starve !== 1'b0) begin errors++; $display("FAIL starve_early%0d: got %b expected 0", i, starve); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (starve !== 1'b1 || fifo_count !== 3'd1) begin errors++; $display("FAIL starve_high%0d: got starve=%b count=%0d expected starve=1 count=1", i, starve, fifo_count); end
      tick();
    end
    set_occ(0);
    #1;
    checks++; if (inj_fire !== 1'b1 || inj_flit !== 10'h2AB) begin errors++; $display("FAIL starve_release: got fire=%b flit=%h expected fire=1 flit=2ab", inj_fire, inj_flit); end
    $display("starve: inject %h", inj_flit);
    tick();
    #1;
    checks++; if (starve !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL starve_clear: got starve=%b count=%0d expected starve=0 count=0", starve, fifo_count); end
  endtask

  task automatic test_back_to_back();
    logic [FLIT_W-1:0] seq [8];
    seq[0] = 10'h101; seq[1] = 10'h102;
    for (int k = 0; k < 6; k++) seq[k+2] = 10'h110 + 10'(k);
    set_occ(4);
    for (int k = 0; k < 2; k++) begin
      lin_valid = 1'b1; lin_data = seq[k];
      tick();
    end
    set_occ(1);
    for (int k = 0; k < 6; k++) begin
      lin_valid = 1'b1; lin_data = seq[k+2];
      #1;
      checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d: got %0d expected 2", k, fifo_count); end
      checks++; if (inj_fire !== 1'b1 || inj_flit !== (seq[k] | 10'h200)) begin errors++; $display("FAIL b2b_flit%0d: got fire=%b flit=%h expected fire=1 flit=%h", k, inj_fire, inj_flit, seq[k] | 10'h200); end
      $display("b2b: push %h inject %h", lin_data, inj_flit);
      tick();
    end
    lin_valid = 1'b0;
    for (int k = 6; k < 8; k++) begin
      #1;
      checks++; if (inj_fire !== 1'b1 || inj_flit !== (seq[k] | 10'h200)) begin errors++; $display("FAIL b2b_drain%0d: got fire=%b flit=%h expected fire=1 flit=%h", k, inj_fire, inj_flit, seq[k] | 10'h200); end
      tick();
    end
    #1;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL b2b_empty: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    set_occ(4);
    for (int k = 0; k < 3; k++) begin
      lin_valid = 1'b1; lin_data = 10'h150 + 10'(k);
      tick();
    end
    lin_valid = 1'b0;
    for (int i = 0; i < STARVE_MAX + 1; i++) tick();
    #1;
    checks++; if (starve !== 1'b1 || fifo_count !== 3'd3) begin errors++; $display("FAIL rstmid_pre: got starve=%b count=%0d expected starve=1 count=3", starve, fifo_count); end
    rst = 1'b1; lin_valid = 1'b1; lin_data = 10'h1EE; set_occ(0);
    tick();
    rst = 1'b0; lin_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (fifo_count !== 3'd0 || starve !== 1'b0 || inj_fire !== 1'b0) begin errors++; $display("FAIL rstmid_post%0d: got count=%0d starve=%b fire=%b expected 0 0 0", i, fifo_count, starve, inj_fire); end
      tick();
    end
    $display("reset_mid: contents discarded");
  endtask

  task automatic test_random();
    bit free, bp, efire;
    logic [FLIT_W-1:0] eflit;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      lin_valid = 1'($urandom_range(0, 1));
      lin_data = FLIT_W'($urandom);
      if ($urandom_range(0, 9) < 4) drive_net(4'b1111);
      else drive_net(4'($urandom));
      #1;
      free = cur_occ() < 4;
      bp = 1'b0;
`ifdef INJ_BYPASS_EN
      bp = (mq.size() == 0) && lin_valid && free;
`endif
      efire = ((mq.size() != 0) && free) || bp;
      eflit = '0;
      if (mq.size() != 0 && free) eflit = mq[0] | 10'h200;
      else if (bp) eflit = lin_data | 10'h200;
      checks++; if (inj_fire !== efire) begin errors++; $display("FAIL rnd_fire c%0d: got %b expected %b", c, inj_fire, efire); end
      checks++; if (inj_flit !== eflit) begin errors++; $display("FAIL rnd_flit c%0d: got %h expected %h", c, inj_flit, eflit); end
      checks++; if (lin_ready !== (mq.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, lin_ready, mq.size() != DEPTH); end
      checks++; if (int'(fifo_count) != mq.size()) begin errors++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, fifo_count, mq.size()); end
      checks++; if (starve !== (mstarve == STARVE_MAX)) begin errors++; $display("FAIL rnd_starve c%0d: got %b expected %b", c, starve, mstarve == STARVE_MAX); end
      if (efire) $display("rnd c%0d: inject %h", c, inj_flit);
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_order();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
